// File: rtl/vedic_mul_arbiter.sv
// Round-robin sharing of one pipelined 16x16 multiplier between NREQ requesters.
// Issue is registered (start one cycle after grant); results return in order, tagged with the requester ID.

module vedic_mul_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  pop_dat_o,
  output logic          pop_ok_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // A pop on an empty FIFO is dropped even when a push lands in the same cycle.
  assign do_pop    = pop_i && (count_q != '0);
  assign do_push   = push_i && (count_q != CW'(DEPTH));
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign pop_ok_o  = do_pop;
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

module vedic_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [15:0]       mul_a,
  output logic [15:0]       mul_b,
  output logic              mul_start,
  input  logic [31:0]       mul_result,
  input  logic              mul_done,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [31:0]       rsp_result,
  output logic              busy,
  output logic              err_spurious
);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [ID_W-1:0] p_q, p_d;
  logic [15:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic            mul_start_q, mul_start_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_result_q, rsp_result_d;
  logic            err_q, err_d;

  logic            eligible, any_vld, hi_found, hs;
  logic [ID_W-1:0] hi_id, lo_id, gnt_id, head_tag;
  logic            pop_ok;
  logic [CW-1:0]   outstanding;
  logic [15:0]     sel_a, sel_b;

  vedic_mul_tag_fifo #(.W(ID_W), .DEPTH(MAX_OUT), .CW(CW)) u_tag_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (hs),
    .push_dat_i (gnt_id),
    .pop_i      (mul_done),
    .pop_dat_o  (head_tag),
    .pop_ok_o   (pop_ok),
    .count_o    (outstanding)
  );

  assign eligible = (outstanding < CW'(MAX_OUT));

  // Rotating priority: lowest valid index at or above p wins, else lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    any_vld  = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (ID_W'(i) >= p_q) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
        end
        any_vld = 1'b1;
        lo_id   = ID_W'(i);
      end
    end
    gnt_id = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (eligible && any_vld && (gnt_id == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        sel_a        = req_a[i*16 +: 16];
        sel_b        = req_b[i*16 +: 16];
      end
    end
  end

  assign hs = |req_ready;

  always_comb begin
    p_d          = p_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_start_d  = hs;
    rsp_valid_d  = pop_ok;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    err_d        = err_q | (mul_done & ~pop_ok);
    if (hs) begin
      p_d     = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      mul_a_d = sel_a;
      mul_b_d = sel_b;
    end
    if (pop_ok) begin
      rsp_id_d     = head_tag;
      rsp_result_d = mul_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q          <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      err_q        <= 1'b0;
    end else begin
      p_q          <= p_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_start_q  <= mul_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      err_q        <= err_d;
    end
  end

  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign mul_start    = mul_start_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign err_spurious = err_q;
  assign busy         = (outstanding != '0) | mul_start_q;
endmodule
